// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB bridge: one AHB transfer at a time becomes one APB
// setup/access sequence on the peripheral selected by the address index.
//
// Handshake: an AHB transfer is accepted on a rising edge where
// HSEL && HTRANS[1] && HREADY and the bridge is in IDLE or ERR2. Its data
// phase completes on the first later edge where HREADYOUT is high. On the
// APB side a transfer completes on the edge where PENABLE and the selected
// PREADY are both high.
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH       = 32,
    parameter int WORD_WIDTH       = 32,
    parameter int N_PERIPH         = 4,
    parameter int PERIPH_ADDR_LSB  = 12,
    parameter int PERIPH_IDX_WIDTH = 3
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic                           HSEL,
    input  logic [ADDR_WIDTH-1:0]          HADDR,
    input  logic [1:0]                     HTRANS,
    input  logic                           HWRITE,
    input  logic [2:0]                     HSIZE,
    input  logic [WORD_WIDTH-1:0]          HWDATA,
    input  logic                           HREADY,
    output logic                           HREADYOUT,
    output logic                           HRESP,
    output logic [WORD_WIDTH-1:0]          HRDATA,
    output logic [N_PERIPH-1:0]            PSEL,
    output logic                           PENABLE,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic                           PWRITE,
    output logic [WORD_WIDTH-1:0]          PWDATA,
    output logic [3:0]                     PSTRB,
    input  logic [N_PERIPH*WORD_WIDTH-1:0] PRDATA,
    input  logic [N_PERIPH-1:0]            PREADY,
    input  logic [N_PERIPH-1:0]            PSLVERR,
    output logic [2:0]                     dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [PERIPH_IDX_WIDTH-1:0] idx_q, idx_d, hidx;
    logic                        accept, hidx_ok;
    logic                        sel_ready, sel_err;
    logic [WORD_WIDTH-1:0]       sel_rdata;
    logic [N_PERIPH-1:0]         psel_d;
    logic [3:0]                  strb_d;
    logic                        unused_htrans0;

    assign unused_htrans0 = HTRANS[0];
    assign hidx      = HADDR[PERIPH_ADDR_LSB +: PERIPH_IDX_WIDTH];
    assign hidx_ok   = (32'(hidx) < 32'(N_PERIPH));
    assign accept    = HSEL && HTRANS[1] && HREADY &&
                       (state_q == S_IDLE || state_q == S_ERR2);
    assign PWDATA    = HWDATA;
    assign dbg_state = state_q;

    // Mux the response of the captured peripheral; out-of-range indices select nothing.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_PERIPH; i++) begin
            if (idx_q == PERIPH_IDX_WIDTH'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // Byte strobes from size and low address bits; reads drive no strobes.
    always_comb begin
        strb_d = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    strb_d = 4'b0001 << HADDR[1:0];
                3'd1:    strb_d = 4'b0011 << {HADDR[1], 1'b0};
                default: strb_d = 4'b1111;
            endcase
        end
    end

    // Next-state logic, plus the index and PSEL value the next state will show.
    always_comb begin
        state_d = state_q;
        idx_d   = accept ? hidx : idx_q;
        psel_d  = '0;
        case (state_q)
            S_IDLE, S_ERR2: begin
                if (accept) begin
                    state_d = hidx_ok ? S_SETUP : S_ERR1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (sel_ready) begin
                    state_d = sel_err ? S_ERR1 : S_IDLE;
                end
            end
            S_ERR1:   state_d = S_ERR2;
            default:  state_d = S_IDLE;
        endcase
        if (state_d == S_SETUP || state_d == S_ACCESS) begin
            for (int i = 0; i < N_PERIPH; i++) begin
                psel_d[i] = (idx_d == PERIPH_IDX_WIDTH'(i));
            end
        end
    end

    // State and all registered bus outputs; reset drops the APB side at once.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PSTRB     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            HREADYOUT <= (state_d == S_IDLE) || (state_d == S_ERR2);
            HRESP     <= (state_d == S_ERR1) || (state_d == S_ERR2);
            PSEL      <= psel_d;
            PENABLE   <= (state_d == S_ACCESS);
            if (accept) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
                PSTRB  <= strb_d;
            end
            if (state_q == S_ACCESS && sel_ready && !sel_err && !PWRITE) begin
                HRDATA <= sel_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: directed transfers from the test plan followed by
// randomized traffic, an APB peripheral responder, and queue-based checking.
module tb_ahb_apb_bridge;

  localparam int NP = 4;
  localparam int W  = 32;

  logic            HCLK, HRESETn, HSEL, HWRITE, HREADY;
  logic [31:0]     HADDR, HWDATA, HRDATA, PADDR, PWDATA;
  logic [1:0]      HTRANS;
  logic [2:0]      HSIZE, dbg_state;
  logic            HREADYOUT, HRESP, PENABLE, PWRITE;
  logic [NP-1:0]   PSEL, PREADY, PSLVERR;
  logic [3:0]      PSTRB;
  logic [NP*W-1:0] PRDATA;

  assign HREADY = HREADYOUT;

  ahb_apb_bridge dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  typedef struct { logic err; logic [31:0] rdata; int waits; } ahb_exp_t;
  typedef struct { logic [3:0] psel; logic [31:0] paddr; logic pwrite;
                   logic [3:0] pstrb; logic [31:0] pwdata; int pen; } apb_exp_t;
  typedef struct { int idx; int wait_n; logic err; logic [31:0] rdata; } resp_t;

  ahb_exp_t ahb_exp_q[$];
  apb_exp_t apb_exp_q[$];
  resp_t    resp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rdata = 32'h0;

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_strb(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    int nb, st;
    logic [3:0] s;
    s = 4'b0000;
    if (!wr) return s;
    if (sz > 3'd2) begin
      nb = 4; st = 0;
    end else begin
      nb = 1 << sz;
      st = (int'(a[1:0]) / nb) * nb;
    end
    for (int b = 0; b < 4; b++) s[b] = (b >= st) && (b < st + nb);
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wdata, input int wait_n, input logic err,
                       input logic [31:0] rdata);
    int idx, n;
    logic rdy;
    ahb_exp_t ae;
    apb_exp_t pe;
    resp_t    re;
    idx = int'(addr[14:12]);
    if (idx >= NP) begin
      ae.err = 1'b1; ae.waits = 1; ae.rdata = last_rdata;
    end else if (err) begin
      ae.err = 1'b1; ae.waits = wait_n + 3; ae.rdata = last_rdata;
    end else begin
      ae.err = 1'b0; ae.waits = wait_n + 2;
      if (!wr) last_rdata = rdata;
      ae.rdata = last_rdata;
    end
    ahb_exp_q.push_back(ae);
    if (idx < NP) begin
      pe.psel = 4'(1 << idx); pe.paddr = addr; pe.pwrite = wr;
      pe.pstrb = model_strb(addr, wr, sz); pe.pwdata = wdata; pe.pen = wait_n + 1;
      apb_exp_q.push_back(pe);
      re.idx = idx; re.wait_n = wait_n; re.err = err; re.rdata = rdata;
      resp_q.push_back(re);
    end
    HSEL = 1'b1; HADDR = addr; HWRITE = wr; HSIZE = sz; HTRANS = 2'b10;
    n = 0;
    do begin
      rdy = HREADYOUT;
      @(posedge HCLK); #1;
      n++;
    end while (!rdy && n < 64);
    if (!rdy) report_fail("accept_timeout");
    HTRANS = 2'b00;
    HSEL   = 1'($urandom_range(0, 1));
    HWDATA = wdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      HSEL   = 1'($urandom_range(0, 1));
      HTRANS = 2'($urandom_range(0, 1));
      HADDR  = 32'h0008_0000 | $urandom_range(0, 32'h7FFF);
      @(posedge HCLK); #1;
    end
    HTRANS = 2'b00;
  endtask

  // ---------------- APB peripheral responder ----------------
  resp_t cur = '{idx: -1, wait_n: 0, err: 1'b0, rdata: 32'h0};
  int    acc_k = 0;
  always begin
    logic tgt_ready;
    @(posedge HCLK); #2;
    tgt_ready = 1'b0;
    if (!HRESETn) begin
      acc_k = 0;
      cur.idx = -1;
    end else begin
      if (PSEL != 0 && !PENABLE) begin
        if (resp_q.size() == 0) report_fail("unexpected_apb_setup");
        else cur = resp_q.pop_front();
        acc_k = 0;
      end
      if (PENABLE) begin
        tgt_ready = (acc_k >= cur.wait_n);
        acc_k++;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (i == cur.idx) begin
        PREADY[i]  = tgt_ready;
        PSLVERR[i] = tgt_ready && cur.err;
        PRDATA[i*W +: W] = cur.rdata;
      end else begin
        PREADY[i]  = 1'b1;
        PSLVERR[i] = 1'b1;
        PRDATA[i*W +: W] = ~cur.rdata ^ 32'(i);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic in_data = 1'b0;
  logic last_hresp = 1'b0;
  int   waits = 0, pen_cnt = 0, setup_cnt = 0;
  always @(negedge HCLK) begin
    ahb_exp_t ae;
    apb_exp_t pe;
    if (!HRESETn) begin
      in_data = 1'b0; pen_cnt = 0; setup_cnt = 0;
    end else begin
      if (in_data) begin
        if (HREADYOUT) begin
          if (ahb_exp_q.size() == 0) report_fail("ahb_unexpected_completion");
          else begin
            ae = ahb_exp_q.pop_front();
            check("hresp", 32'(HRESP), 32'(ae.err));
            check("hresp_prev", 32'(last_hresp), 32'(ae.err));
            check("hrdata", HRDATA, ae.rdata);
            check("wait_states", waits, ae.waits);
          end
          in_data = 1'b0;
        end else begin
          waits++;
          last_hresp = HRESP;
        end
      end else begin
        check("idle_okay", {30'b0, HREADYOUT, HRESP}, 32'b10);
      end
      if (HSEL && HTRANS[1] && HREADY) begin
        in_data = 1'b1; waits = 0; last_hresp = 1'b0;
      end
      if (PSEL != 0 && !PENABLE) setup_cnt++;
      if (PENABLE) pen_cnt++;
      if (PENABLE && (PSEL & PREADY) != 0) begin
        if (apb_exp_q.size() == 0) report_fail("apb_unexpected_access");
        else begin
          pe = apb_exp_q.pop_front();
          check("psel", 32'(PSEL), 32'(pe.psel));
          check("paddr", PADDR, pe.paddr);
          check("pwrite", 32'(PWRITE), 32'(pe.pwrite));
          check("pstrb", 32'(PSTRB), 32'(pe.pstrb));
          check("pwdata", PWDATA, pe.pwdata);
          check("penable_cycles", pen_cnt, pe.pen);
          check("setup_cycles", setup_cnt, 1);
        end
        pen_cnt = 0; setup_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HWDATA = 32'h0; PREADY = '0; PSLVERR = '0; PRDATA = '0;
    #12;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_pstrb", 32'(PSTRB), 32'd0);
    @(negedge HCLK); @(negedge HCLK); #2; HRESETn = 1'b1;
    @(posedge HCLK); #1;

    issue(32'h0008_1004, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    idle(2);
    issue(32'h0008_0002, 1'b1, 3'd1, 32'h1234_0000, 0, 1'b0, 32'h0);
    issue(32'h0008_3003, 1'b1, 3'd0, 32'hAB00_0000, 0, 1'b0, 32'h0);
    idle(1);
    issue(32'h0008_2000, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'hCAFE_0002);
    idle(1);
    issue(32'h0008_3000, 1'b0, 3'd2, 32'h0, 0, 1'b1, 32'h5555_AAAA);
    idle(1);
    issue(32'h0008_5000, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0);
    idle(1);
    issue(32'h0008_0010, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0000_1111);
    issue(32'h0008_1020, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0000_2222);
    issue(32'h0008_7000, 1'b1, 3'd2, 32'h9, 0, 1'b0, 32'h0);
    issue(32'h0008_2004, 1'b0, 3'd2, 32'h0, 1, 1'b0, 32'h0000_3333);

    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      sz = (($urandom_range(0, 9)) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a  = 32'h0008_0000 | (32'($urandom_range(0, 7)) << 12) | 32'($urandom_range(0, 32'hFFF));
      if (sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      issue(a, 1'($urandom_range(0, 1)), sz, $urandom, $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0), $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(8);

    // Reset in the middle of an APB access abandons the transfer.
    issue(32'h0008_2008, 1'b1, 3'd2, 32'h7777_8888, 10, 1'b0, 32'h0);
    @(negedge HCLK); @(negedge HCLK); #1;
    check("pre_rst_penable", 32'(PENABLE), 32'd1);
    HRESETn = 1'b0;
    #1;
    check("midrst_psel", 32'(PSEL), 32'd0);
    check("midrst_penable", 32'(PENABLE), 32'd0);
    check("midrst_pstrb", 32'(PSTRB), 32'd0);
    check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("midrst_hresp", 32'(HRESP), 32'd0);
    check("midrst_hrdata", HRDATA, 32'h0);
    check("midrst_pwrite", 32'(PWRITE), 32'd0);
    ahb_exp_q.delete(); apb_exp_q.delete(); resp_q.delete();
    last_rdata = 32'h0;
    @(negedge HCLK); @(negedge HCLK); #2; HRESETn = 1'b1;
    @(posedge HCLK); #1;
    issue(32'h0008_1000, 1'b1, 3'd0, 32'h0000_00EE, 0, 1'b0, 32'h0);
    issue(32'h0008_3004, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'h1357_9BDF);
    idle(10);

    check("ahb_queue_drained", ahb_exp_q.size(), 0);
    check("apb_queue_drained", apb_exp_q.size(), 0);
    check("resp_queue_drained", resp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    report_fail("global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
